// File: rtl/otter_cu_fsm.sv
// Otter RV32I multicycle control: INIT -> FETCH -> EXEC [-> WRITEBACK] [-> INTRPT] -> FETCH.
// Two cycles per instruction, three for loads, plus one when an interrupt is taken; no backpressure.
module otter_cu_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic        intr,
    input  logic        csr_mie,
    output logic        PCWrite,
    output logic [2:0]  pcSource,
    output logic        regWrite,
    output logic [1:0]  rf_wr_sel,
    output logic        memRDEN1,
    output logic        memRDEN2,
    output logic        memWE2,
    output logic        csr_WE,
    output logic        int_taken,
    output logic        mret_exec,
    output logic        rst_out
);

    typedef enum logic [2:0] {
        INIT,
        FETCH,
        EXEC,
        WRITEBACK,
        INTRPT
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t state, next_state;
    logic   pend;
    logic   br_taken;
    logic   irq_go;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign func3     = ir[14:12];
    assign unused_ir = ^{ir[19:15], ir[11:7]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            pend  <= 1'b0;
        end else begin
            state <= next_state;
            // Entering the handler consumes the request; INIT ignores intr entirely.
            if (state == INTRPT)
                pend <= 1'b0;
            else if (intr && state != INIT)
                pend <= 1'b1;
        end
    end

    always_comb begin
        br_taken = 1'b0;
        case (func3)
            3'b000:  br_taken = br_eq;
            3'b001:  br_taken = !br_eq;
            3'b100:  br_taken = br_lt;
            3'b101:  br_taken = !br_lt;
            3'b110:  br_taken = br_ltu;
            3'b111:  br_taken = !br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    assign irq_go = pend && csr_mie;

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        pcSource   = 3'd0;
        regWrite   = 1'b0;
        rf_wr_sel  = 2'd0;
        memRDEN1   = 1'b0;
        memRDEN2   = 1'b0;
        memWE2     = 1'b0;
        csr_WE     = 1'b0;
        int_taken  = 1'b0;
        mret_exec  = 1'b0;
        rst_out    = 1'b0;

        case (state)
            INIT: begin
                rst_out    = 1'b1;
                next_state = FETCH;
            end

            FETCH: begin
                memRDEN1   = 1'b1;
                next_state = EXEC;
            end

            EXEC: begin
                next_state = irq_go ? INTRPT : FETCH;
                PCWrite    = 1'b1;
                case (opcode)
                    OPC_LOAD: begin
                        PCWrite    = 1'b0;
                        memRDEN2   = 1'b1;
                        next_state = WRITEBACK;
                    end
                    OPC_STORE: memWE2 = 1'b1;
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                        regWrite  = 1'b1;
                        rf_wr_sel = 2'd3;
                    end
                    OPC_JAL: begin
                        regWrite = 1'b1;
                        pcSource = 3'd3;
                    end
                    OPC_JALR: begin
                        regWrite = 1'b1;
                        pcSource = 3'd1;
                    end
                    OPC_BRANCH: pcSource = br_taken ? 3'd2 : 3'd0;
                    OPC_SYSTEM: begin
                        if (func3 == 3'b001) begin
                            regWrite  = 1'b1;
                            rf_wr_sel = 2'd1;
                            csr_WE    = 1'b1;
                        end else if (func3 == 3'b000 && ir[31:20] == 12'h302) begin
                            mret_exec = 1'b1;
                            pcSource  = 3'd5;
                        end
                    end
                    default: ;
                endcase
            end

            WRITEBACK: begin
                regWrite   = 1'b1;
                rf_wr_sel  = 2'd2;
                PCWrite    = 1'b1;
                next_state = irq_go ? INTRPT : FETCH;
            end

            INTRPT: begin
                int_taken  = 1'b1;
                PCWrite    = 1'b1;
                pcSource   = 3'd4;
                next_state = FETCH;
            end

            default: next_state = INIT;
        endcase
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm: walks instructions cycle by cycle and compares the full output bundle.
module tb_otter_cu_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic        br_eq, br_lt, br_ltu, intr, csr_mie;
    logic        PCWrite;
    logic [2:0]  pcSource;
    logic        regWrite;
    logic [1:0]  rf_wr_sel;
    logic        memRDEN1, memRDEN2, memWE2, csr_WE, int_taken, mret_exec, rst_out;

    int total = 0;
    int bad   = 0;

    otter_cu_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .ir        (ir),
        .br_eq     (br_eq),
        .br_lt     (br_lt),
        .br_ltu    (br_ltu),
        .intr      (intr),
        .csr_mie   (csr_mie),
        .PCWrite   (PCWrite),
        .pcSource  (pcSource),
        .regWrite  (regWrite),
        .rf_wr_sel (rf_wr_sel),
        .memRDEN1  (memRDEN1),
        .memRDEN2  (memRDEN2),
        .memWE2    (memWE2),
        .csr_WE    (csr_WE),
        .int_taken (int_taken),
        .mret_exec (mret_exec),
        .rst_out   (rst_out)
    );

    always #5 clk = ~clk;

    // {PCWrite, pcSource, regWrite, rf_wr_sel, memRDEN1, memRDEN2, memWE2, csr_WE, int_taken, mret_exec, rst_out}
    logic [13:0] outs;
    assign outs = {PCWrite, pcSource, regWrite, rf_wr_sel, memRDEN1, memRDEN2,
                   memWE2, csr_WE, int_taken, mret_exec, rst_out};

    function automatic logic [13:0] ov(input logic pcw, input logic [2:0] pcs, input logic rw,
                                       input logic [1:0] rsel, input logic r1, input logic r2,
                                       input logic we2, input logic cwe, input logic it,
                                       input logic mr, input logic ro);
        return {pcw, pcs, rw, rsel, r1, r2, we2, cwe, it, mr, ro};
    endfunction

    localparam logic [13:0] O_INIT  = 14'b0_000_0_00_0_0_0_0_0_0_1;
    localparam logic [13:0] O_FETCH = 14'b0_000_0_00_1_0_0_0_0_0_0;
    localparam logic [13:0] O_ALU   = 14'b1_000_1_11_0_0_0_0_0_0_0;
    localparam logic [13:0] O_LDEX  = 14'b0_000_0_00_0_1_0_0_0_0_0;
    localparam logic [13:0] O_WB    = 14'b1_000_1_10_0_0_0_0_0_0_0;
    localparam logic [13:0] O_INTR  = 14'b1_100_0_00_0_0_0_0_1_0_0;
    localparam logic [13:0] O_NOP   = 14'b1_000_0_00_0_0_0_0_0_0_0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [13:0] exp);
        @(posedge clk);
        #2;
        check(tag, 32'(outs), 32'(exp));
    endtask

    // Called while in FETCH: present iw, check EXEC, then check the return to FETCH.
    task automatic instr(input string tag, input logic [31:0] iw, input logic [13:0] exp_ex);
        ir = iw;
        step({tag, "_ex"}, exp_ex);
        step({tag, "_fetch"}, O_FETCH);
    endtask

    initial begin
        reset = 1'b1; ir = 32'h0000_0013;
        br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0; intr = 1'b0; csr_mie = 1'b0;

        step("reset_1", O_INIT);
        step("reset_2", O_INIT);
        reset = 1'b0;
        step("fetch_0", O_FETCH);
        instr("addi", 32'h0000_0013, O_ALU);

        // Load: EXEC, WRITEBACK, FETCH -> three-cycle period.
        ir = 32'h0000_A083;
        step("lw_ex", O_LDEX);
        step("lw_wb", O_WB);
        step("lw_fetch", O_FETCH);

        instr("sw", 32'h0020_A023, ov(1, 3'd0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0));

        br_eq = 1'b1;
        instr("beq_t", 32'h0020_8463, ov(1, 3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        br_eq = 1'b0;
        instr("beq_nt", 32'h0020_8463, O_NOP);
        instr("bgeu_t", 32'h0020_F463, ov(1, 3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        br_lt = 1'b1;
        instr("blt_t", 32'h0020_C463, ov(1, 3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        br_eq = 1'b1; br_ltu = 1'b1;
        instr("bne_nt", 32'h0020_9463, O_NOP);
        instr("br_f3_010", 32'h0020_A463, O_NOP);
        br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;

        instr("jal", 32'h0080_00EF, ov(1, 3'd3, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        instr("jalr", 32'h0000_80E7, ov(1, 3'd1, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        instr("csrrw", 32'h3052_9073, ov(1, 3'd0, 1, 2'd1, 0, 0, 0, 1, 0, 0, 0));
        instr("mret", 32'h3020_0073, ov(1, 3'd5, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0));
        instr("illegal", 32'hFFFF_FFFF, O_NOP);

        // Interrupt pulsed in FETCH with MIE set: instruction completes, then INTRPT.
        csr_mie = 1'b1; intr = 1'b1; ir = 32'h0000_0013;
        step("irq_ex", O_ALU);
        intr = 1'b0;
        step("irq_entry", O_INTR);
        step("irq_fetch", O_FETCH);
        instr("irq_cleared", 32'h0000_0013, O_ALU);

        // MIE clear: request stays pending across instructions until MIE rises.
        csr_mie = 1'b0; intr = 1'b1; ir = 32'h0000_0013;
        step("mask_ex", O_ALU);
        intr = 1'b0;
        step("mask_fetch", O_FETCH);
        ir = 32'h0000_A083;
        step("mask_lw_ex", O_LDEX);
        step("mask_lw_wb", O_WB);
        step("mask_lw_fetch", O_FETCH);
        csr_mie = 1'b1;
        ir = 32'h0000_0013;
        step("unmask_ex", O_ALU);
        step("unmask_entry", O_INTR);
        step("unmask_fetch", O_FETCH);

        // Reset mid-load drops the pending request and the pending writeback.
        csr_mie = 1'b0; intr = 1'b1; ir = 32'h0000_A083;
        step("rst_lw_ex", O_LDEX);
        intr = 1'b0; reset = 1'b1;
        step("rst_mid_load", O_INIT);
        reset = 1'b0; intr = 1'b1;
        step("rst_fetch", O_FETCH);
        intr = 1'b0; csr_mie = 1'b1;
        instr("rst_no_irq", 32'h0000_0013, O_ALU);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
